// File: rtl/eaglesong_pkg.sv
// Shared types, constants and the rate-block packing helper for the Eaglesong
// sponge datapath.
package eaglesong_pkg;

  localparam int STATE_WORDS = 16;
  localparam int RATE_WORDS  = 8;
  localparam int RATE_BYTES  = 32;
  localparam int NUM_ROUNDS  = 43;

  typedef enum logic [1:0] {
    ABSORB   = 2'd0,
    PERM_ABS = 2'd1,
    SQUEEZE  = 2'd2,
    PERM_SQ  = 2'd3
  } sponge_state_e;

  typedef logic [STATE_WORDS-1:0][31:0] state_t;
  typedef logic [RATE_WORDS-1:0][31:0]  rate_t;

  function automatic logic [31:0] rotl32(input logic [31:0] v, input logic [4:0] s);
    logic [63:0] w;
    w = {v, v} << s;
    return w[63:32];
  endfunction

  // Bytes are packed MSB-first and right-aligned inside each word; a missing
  // byte contributes no shift, so a short final word stays right-aligned.
  function automatic rate_t pack_block(input logic [255:0] data, input logic [5:0] nbytes,
                                       input logic last, input logic [7:0] delim);
    rate_t       words;
    logic [6:0]  nb;
    logic [6:0]  idx;
    logic [31:0] acc;
    nb    = (nbytes > 6'(RATE_BYTES)) ? 7'(RATE_BYTES) : {1'b0, nbytes};
    words = '0;
    for (int j = 0; j < RATE_WORDS; j++) begin
      acc = 32'd0;
      for (int k = 0; k < 4; k++) begin
        idx = 7'(4 * j + k);
        if (idx < nb) begin
          acc = {acc[23:0], data[8*(4*j+k) +: 8]};
        end else if (last && (idx == nb)) begin
          acc = {acc[23:0], delim};
        end else begin
          acc = acc;
        end
      end
      words[j] = acc;
    end
    return words;
  endfunction

endpackage

// File: rtl/eaglesong_sponge_stream_if.sv
// Block-stream handshake bundle: rate-block input and squeeze-block output.
interface eaglesong_sponge_stream_if;

  logic         in_valid;
  logic         in_ready;
  logic [255:0] in_data;
  logic [5:0]   in_bytes;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_data;
  logic         out_last;

  modport master (
    output in_valid, in_data, in_bytes, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_bytes, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/eaglesong_all_permutations.sv
// Iterative 43-round Eaglesong-style permutation, one round per clock.
// Latency from i_start to o_done is NUM_ROUNDS cycles; o_state holds afterwards.
module eaglesong_all_permutations
  import eaglesong_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   i_start,
  input  state_t i_state,
  output state_t o_state,
  output logic   o_done
);

  localparam logic [4:0]  ROT_A [STATE_WORDS] = '{5'd2, 5'd13, 5'd4, 5'd3, 5'd27, 5'd3, 5'd17, 5'd3,
                                                  5'd18, 5'd12, 5'd4, 5'd4, 5'd12, 5'd7, 5'd7, 5'd1};
  localparam logic [4:0]  ROT_B [STATE_WORDS] = '{5'd4, 5'd22, 5'd19, 5'd14, 5'd31, 5'd8, 5'd26, 5'd12,
                                                  5'd22, 5'd18, 5'd7, 5'd31, 5'd27, 5'd17, 5'd8, 5'd13};
  localparam logic [31:0] INJ_SEED = 32'hB7E1_5163;

  state_t     r_x;
  logic [5:0] r_rnd;
  logic       r_active;
  logic       r_done;

  // Linear word mix, per-word circulant, constant injection, then add-rotate-add on word pairs.
  function automatic state_t es_round(input state_t x, input logic [5:0] rnd);
    state_t      y;
    logic [31:0] t;
    for (int i = 0; i < STATE_WORDS; i++) begin
      y[i] = x[i] ^ x[(i + 1) % STATE_WORDS] ^ x[(i + 4) % STATE_WORDS];
    end
    for (int i = 0; i < STATE_WORDS; i++) begin
      t    = y[i];
      y[i] = t ^ rotl32(t, ROT_A[i]) ^ rotl32(t, ROT_B[i])
               ^ rotl32(INJ_SEED, 5'(2 * i + 1)) ^ {26'd0, rnd};
    end
    for (int i = 0; i < STATE_WORDS; i += 2) begin
      y[i]     = y[i] + y[i+1];
      y[i]     = rotl32(y[i], 5'd8);
      y[i+1]   = rotl32(y[i+1], 5'd24);
      y[i+1]   = y[i] + y[i+1];
    end
    return y;
  endfunction

  // Round sequencer; a start always restarts from i_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x      <= '0;
      r_rnd    <= 6'd0;
      r_active <= 1'b0;
      r_done   <= 1'b0;
    end else if (i_start) begin
      r_x      <= es_round(i_state, 6'd0);
      r_rnd    <= 6'd1;
      r_active <= 1'b1;
      r_done   <= 1'b0;
    end else if (r_active) begin
      r_x   <= es_round(r_x, r_rnd);
      r_rnd <= r_rnd + 6'd1;
      if (r_rnd == 6'(NUM_ROUNDS - 1)) begin
        r_active <= 1'b0;
        r_done   <= 1'b1;
      end else begin
        r_done   <= 1'b0;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign o_state = r_x;
  assign o_done  = r_done;

endmodule

// File: rtl/eaglesong_sponge_stream.sv
// Streaming Eaglesong sponge: multi-block absorb with delimiter padding and
// OUT_BLOCKS-block squeeze. Define EAGLESONG_SPONGE_PROTO_CHECK_EN for the sticky err checker.
module eaglesong_sponge_stream
  import eaglesong_pkg::*;
#(
  parameter int         OUT_BLOCKS = 1,
  parameter logic [7:0] DELIMITER  = 8'h06
) (
  input  logic                     clk,
  input  logic                     rst,
  eaglesong_sponge_stream_if.slave bus,
  output logic                     busy,
  output logic                     err
);

  localparam int               CNT_W    = $clog2(OUT_BLOCKS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OUT_BLOCKS - 1);

  sponge_state_e    r_fsm;
  state_t           r_state;
  logic             r_start;
  logic             r_restart;
  logic             r_last_seen;
  logic             r_pad_pend;
  logic [CNT_W-1:0] r_cnt;
  logic             r_in_ready;
  logic             r_busy;
  logic             r_out_valid;
  logic             r_out_last;
  logic [255:0]     r_out_data;

  rate_t  w_packed;
  state_t w_absorbed;
  state_t w_padded;
  state_t w_perm_out;
  logic   w_perm_done;
  logic   w_done;
  logic   w_hs_in;
  logic   w_full;

  eaglesong_all_permutations u_perm (
    .clk     (clk),
    .rst     (rst),
    .i_start (r_start),
    .i_state (r_state),
    .o_state (w_perm_out),
    .o_done  (w_perm_done)
  );

  assign w_hs_in = bus.in_valid && r_in_ready;
  assign w_full  = (bus.in_bytes >= 6'(RATE_BYTES));
  assign w_done  = w_perm_done && !r_start;

  // Rate XOR for absorb and the delimiter fold for the extra pad block.
  always_comb begin
    w_packed   = pack_block(bus.in_data, bus.in_bytes, bus.in_last, DELIMITER);
    w_absorbed = r_state;
    for (int j = 0; j < RATE_WORDS; j++) begin
      w_absorbed[j] = r_state[j] ^ w_packed[j];
    end
    w_padded    = w_perm_out;
    w_padded[0] = w_perm_out[0] ^ {24'd0, DELIMITER};
  end

  // Sponge control FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm       <= ABSORB;
      r_state     <= '0;
      r_start     <= 1'b0;
      r_restart   <= 1'b0;
      r_last_seen <= 1'b0;
      r_pad_pend  <= 1'b0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_start   <= r_restart;
      r_restart <= 1'b0;
      case (r_fsm)
        ABSORB: begin
          if (w_hs_in) begin
            r_state     <= w_absorbed;
            r_last_seen <= bus.in_last;
            r_pad_pend  <= bus.in_last && w_full;
            r_start     <= 1'b1;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b1;
            r_fsm       <= PERM_ABS;
          end else begin
            r_fsm <= ABSORB;
          end
        end
        PERM_ABS: begin
          if (w_done) begin
            if (r_pad_pend) begin
              // The pad block restart is delayed one cycle behind the state write.
              r_state    <= w_padded;
              r_pad_pend <= 1'b0;
              r_restart  <= 1'b1;
            end else if (r_last_seen) begin
              r_state     <= w_perm_out;
              r_cnt       <= '0;
              r_out_valid <= 1'b1;
              r_out_last  <= (OUT_BLOCKS == 1);
              r_out_data  <= w_perm_out[RATE_WORDS-1:0];
              r_fsm       <= SQUEEZE;
            end else begin
              r_state    <= w_perm_out;
              r_in_ready <= 1'b1;
              r_busy     <= 1'b0;
              r_fsm      <= ABSORB;
            end
          end else begin
            r_fsm <= PERM_ABS;
          end
        end
        SQUEEZE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            if (r_out_last) begin
              r_state     <= '0;
              r_out_data  <= '0;
              r_out_last  <= 1'b0;
              r_cnt       <= '0;
              r_last_seen <= 1'b0;
              r_in_ready  <= 1'b1;
              r_busy      <= 1'b0;
              r_fsm       <= ABSORB;
            end else begin
              r_cnt   <= r_cnt + CNT_W'(1);
              r_start <= 1'b1;
              r_fsm   <= PERM_SQ;
            end
          end else begin
            r_fsm <= SQUEEZE;
          end
        end
        PERM_SQ: begin
          if (w_done) begin
            r_state     <= w_perm_out;
            r_out_valid <= 1'b1;
            r_out_last  <= (r_cnt == LAST_CNT);
            r_out_data  <= w_perm_out[RATE_WORDS-1:0];
            r_fsm       <= SQUEEZE;
          end else begin
            r_fsm <= PERM_SQ;
          end
        end
        default: begin
          r_fsm <= ABSORB;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
  assign bus.out_data  = r_out_data;
  assign busy          = r_busy;

`ifdef EAGLESONG_SPONGE_PROTO_CHECK_EN
  logic r_err;

  // Sticky flag for oversize counts or short non-final blocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_hs_in && ((bus.in_bytes > 6'(RATE_BYTES)) ||
                             ((bus.in_bytes != 6'(RATE_BYTES)) && !bus.in_last))) begin
      r_err <= 1'b1;
    end else begin
      r_err <= r_err;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/eaglesong_sponge_stream.md
# eaglesong_sponge_stream

Parametrised successor to the single-shot Eaglesong digest. Hashes messages of any length through a rate-block streaming input (valid/ready) and produces `OUT_BLOCKS` 256-bit squeeze blocks on a valid/ready output. It implements full sponge absorb (multi-block, delimiter padding including the extra pad block) and multi-block squeeze, and wraps one `eaglesong_all_permutations` instance. It sits between the message framer and the digest consumer.

## Interface
- `OUT_BLOCKS`, default 1: number of 32-byte squeeze blocks per message (≥1).
- `DELIMITER`, default 8'h06: padding byte appended after the last message byte.
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: input block valid.
- `in_ready` out 1: block accepts input; high only in ABSORB.
- `in_data` in 256: message bytes; byte n at [8n+7:8n].
- `in_bytes` in 6: valid bytes in block, 0..32; must be 32 unless `in_last`.
- `in_last` in 1: final block of message.
- `out_valid` out 1: squeeze block valid.
- `out_ready` in 1: consumer accepts.
- `out_data` out 256: `state[j]` at [32j+31:32j], j=0..7 (little-endian bytes).
- `out_last` out 1: final squeeze block of message.
- `busy` out 1: high in any state except ABSORB.
- `err` out 1: sticky protocol error (see Configuration).

## Operation
- State: 16×32-bit words, zero at reset and after the last output handshake. Rate is words 0..7. Capacity is words 8..15.
- Packing: for word j, take bytes 4j..4j+3 in order. Keep only message bytes (index < `in_bytes`) and the delimiter (index == `in_bytes`, last block only). Pack them MSB-first, right-aligned. Absent bytes shift nothing. Example: `in_bytes`=1, byte0=0x41 gives word0=0x0000_4106.
- FSM states (package enum): ABSORB, PERM_ABS, SQUEEZE, PERM_SQ.
- ABSORB: on `in_valid`&&`in_ready`, `state[7:0]` ^= packed words, then go to PERM_ABS. Latch `last_seen`=`in_last`. Latch `pad_pend`=`in_last`&&`in_bytes`==32.
- Permutation start is a registered one-cycle pulse in the cycle after a state update. The permutation input is the state register.
- PERM_ABS, on `done`: `state` <= permutation output. Then:
  - If `pad_pend`: word0 ^= 32'h0000_00{DELIMITER}, clear `pad_pend`, restart the permutation, stay in PERM_ABS.
  - Else if `last_seen`: go to SQUEEZE with `cnt`=0.
  - Else: go to ABSORB.
- SQUEEZE: `out_valid`=1, `out_last`=(`cnt`==OUT_BLOCKS-1). On `out_ready`:
  - If last: zero the state and go to ABSORB.
  - Else: `cnt`++, start the permutation, go to PERM_SQ.
- PERM_SQ, on `done`: capture the state and go to SQUEEZE. No trailing permutation after the final block.
- `done` is ignored outside PERM_* states and is ignored in the same cycle as the start pulse.
- `cnt` width is $clog2(OUT_BLOCKS+1).
- `in_bytes`=0 with `in_last`: a delimiter-only block (word0=0x0000_0006).

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_last`=0, `out_data`=0, `busy`=0, `err`=0, FSM=ABSORB, `cnt`=0, `pad_pend`=0.
- P is the permutation latency, counted from start to `done`.
- Single final block: handshake at cycle 0, start at cycle 1, `done` at 1+P, `out_valid` at 2+P.
- The extra pad block adds P+2 cycles.
- Each non-final absorb block has a throughput of P+2 cycles.
- `out_data` holds stable while `out_valid`&&!`out_ready` (stall of any length).
- Each later squeeze block appears P+2 cycles after the prior handshake.
- Back-to-back messages: `in_ready` rises in the cycle after the last output handshake.
- `rst` mid-operation: all registers return to reset values next cycle. The in-flight permutation is abandoned and its stale `done` is ignored.

## Configuration
- `EAGLESONG_SPONGE_PROTO_CHECK_EN` defined: `err` is set, and held until `rst`, on an accepted block with `in_bytes`>32, or with `in_bytes`!=32 and !`in_last`. The block is still absorbed as if `in_bytes` were clamped to 32.
- Not defined: `err` is tied 0, no checker logic exists, and illegal `in_bytes` gives undefined digests.

## Structure
- Shared package `eaglesong_pkg`: `STATE_WORDS`=16, `RATE_WORDS`=8, `RATE_BYTES`=32, FSM state enum, `state_t` (16×32 array type), and a packing function (block bytes + count + last + delimiter → 8 words).
- One sub-module: `eaglesong_all_permutations`, instantiated once. It has no other children.

## Test plan
- `in_bytes`=1, byte0=0x41, last, OUT_BLOCKS=1 → permutation input word0=0x0000_4106, words 1..15=0; `out_valid` at cycle 2+P; digest equals the C model.
- Full 32-byte last block (bytes 0x00..0x1F) → two permutations observed; the second input word0 has 0x06 XORed in; digest matches the model.
- Three-block 70-byte message with OUT_BLOCKS=3, `out_ready` stalled 5 cycles on block 1 → `out_data` stable during the stall; `out_last` only on block 2; all 96 bytes match the model.
- Empty message (`in_bytes`=0, last) → absorbed word0=0x0000_0006; digest matches the model; then an immediate second message gives identical results to a fresh run.
- `rst` pulsed in PERM_ABS and then in SQUEEZE → next cycle `in_ready`=1, `out_valid`=0, state zero; a following message hashes correctly.
- With the macro defined: non-last block with `in_bytes`=16 → `err`=1, sticky until `rst`. Without the macro → `err` stays 0.
